// File: rtl/lab8_pkg.sv
// Shared definitions for the Q-latch edge counter: FSM state encodings
// and the default debounce / counter widths.
package lab8_pkg;

  typedef enum logic [1:0] {
    S_LO      = 2'b00,
    S_WAIT_HI = 2'b01,
    S_HI      = 2'b11,
    S_WAIT_LO = 2'b10
  } state_t;

  localparam int unsigned DEB_CYCLES_DEF = 4;
  localparam int unsigned CNT_W_DEF      = 8;
  localparam int unsigned DEB_CNT_W      = 8;

endpackage : lab8_pkg

// File: rtl/q_edge_counter_sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync2 (
  input  logic CLK,
  input  logic RST_N,
  input  logic D,
  output logic Q
);

  logic meta;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      meta <= 1'b0;
      Q    <= 1'b0;
    end else begin
      meta <= D;
      Q    <= meta;
    end
  end

endmodule : sync2

// File: rtl/q_edge_counter.sv
// Debounces the Q output of an upstream latch, emits RISE/FALL pulses on
// accepted transitions and counts accepted rising edges with sticky wrap flag.
module q_edge_counter
  import lab8_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Q_IN,
  input  logic             CLR,
  output logic             Q_STABLE,
  output logic             RISE,
  output logic             FALL,
  output logic [CNT_W-1:0] COUNT,
  output logic             OVF
);

  localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEB_CYCLES - 1);

  logic                 sync;
  state_t               state, state_n;
  logic [DEB_CNT_W-1:0] deb_cnt, deb_n;
  logic                 rise_n, fall_n, q_stable_n;

  sync2 u_sync2 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .D     (Q_IN),
    .Q     (sync)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_LO;
      deb_cnt  <= '0;
      Q_STABLE <= 1'b0;
      RISE     <= 1'b0;
      FALL     <= 1'b0;
    end else begin
      state    <= state_n;
      deb_cnt  <= deb_n;
      Q_STABLE <= q_stable_n;
      RISE     <= rise_n;
      FALL     <= fall_n;
    end
  end

  always_comb begin
    state_n = state;
    deb_n   = deb_cnt;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    case (state)
      S_LO: begin
        if (sync) begin
          state_n = S_WAIT_HI;
          deb_n   = '0;
        end
      end
      S_WAIT_HI: begin
        if (!sync) begin
          state_n = S_LO;
        end else if (deb_cnt >= DEB_LAST) begin
          state_n = S_HI;
          rise_n  = 1'b1;
        end else begin
          deb_n = deb_cnt + 8'd1;
        end
      end
      S_HI: begin
        if (!sync) begin
          state_n = S_WAIT_LO;
          deb_n   = '0;
        end
      end
      S_WAIT_LO: begin
        if (sync) begin
          state_n = S_HI;
        end else if (deb_cnt >= DEB_LAST) begin
          state_n = S_LO;
          fall_n  = 1'b1;
        end else begin
          deb_n = deb_cnt + 8'd1;
        end
      end
      default: state_n = S_LO;
    endcase
    q_stable_n = (state_n == S_HI) || (state_n == S_WAIT_LO);
  end

  // Counter advances on the same edge that registers RISE; CLR wins over it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      COUNT <= '0;
      OVF   <= 1'b0;
    end else if (CLR) begin
      COUNT <= '0;
      OVF   <= 1'b0;
    end else if (rise_n) begin
      COUNT <= COUNT + CNT_W'(1);
      if (&COUNT) OVF <= 1'b1;
    end
  end

endmodule : q_edge_counter

// File: tb/tb_q_edge_counter.sv
// Directed self-checking bench for q_edge_counter (DEB_CYCLES=4, CNT_W=8).
module tb_q_edge_counter;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       Q_IN = 1'b0;
  logic       CLR = 1'b0;
  logic       Q_STABLE, RISE, FALL, OVF;
  logic [7:0] COUNT;

  int checks = 0;
  int errors = 0;

  q_edge_counter #(.DEB_CYCLES(4), .CNT_W(8)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .Q_IN     (Q_IN),
    .CLR      (CLR),
    .Q_STABLE (Q_STABLE),
    .RISE     (RISE),
    .FALL     (FALL),
    .COUNT    (COUNT),
    .OVF      (OVF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Runs n cycles, tallying pulses and flagging overlap or multi-cycle pulses.
  task automatic run(input int n, output int rises, output int falls);
    logic prev_r, prev_f;
    rises = 0; falls = 0; prev_r = 1'b0; prev_f = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (RISE && !prev_r) rises++;
      if (FALL && !prev_f) falls++;
      if (RISE && FALL) chk("rise_fall_overlap", 1, 0);
      if ((RISE && prev_r) || (FALL && prev_f)) chk("pulse_width", 2, 1);
      prev_r = RISE; prev_f = FALL;
    end
  endtask

  task automatic pulse_q;
    Q_IN = 1'b1; tick(10);
    Q_IN = 1'b0; tick(10);
  endtask

  task automatic do_clr;
    CLR = 1'b1; tick(1); CLR = 1'b0;
  endtask

  initial begin
    int r, f;
    logic hist[0:119];

    // Reset with Q_IN already high
    Q_IN = 1'b1;
    tick(3);
    chk("rst_qstable", Q_STABLE, 0);
    chk("rst_rise", RISE, 0);
    chk("rst_fall", FALL, 0);
    chk("rst_count", COUNT, 0);
    chk("rst_ovf", OVF, 0);
    RST_N = 1'b1;
    tick(6);
    chk("post_rst_rise_e6", RISE, 0);
    chk("post_rst_qst_e6", Q_STABLE, 0);
    tick(1);
    chk("post_rst_rise_e7", RISE, 1);
    chk("post_rst_qst_e7", Q_STABLE, 1);
    chk("post_rst_count", COUNT, 1);
    tick(1);
    chk("post_rst_rise_e8", RISE, 0);

    // Falling latency mirrors the rising one
    tick(3);
    Q_IN = 1'b0;
    tick(6);
    chk("fall_e6", FALL, 0);
    tick(1);
    chk("fall_e7", FALL, 1);
    chk("fall_qst", Q_STABLE, 0);
    chk("fall_count", COUNT, 1);
    tick(4);

    do_clr();
    chk("clr_count", COUNT, 0);
    chk("clr_ovf", OVF, 0);

    // Clean toggling every 10 cycles; Q_STABLE lags Q_IN by 7 edges
    r = 0; f = 0;
    begin
      logic prev_r, prev_f;
      prev_r = 1'b0; prev_f = 1'b0;
      for (int i = 0; i < 110; i++) begin
        if (i < 100 && (i % 10) == 0) Q_IN = ~Q_IN;
        hist[i] = Q_IN;
        @(negedge CLK);
        chk("toggle_qstable", Q_STABLE, (i >= 6) ? hist[i-6] : 1'b0);
        if (RISE && FALL) chk("toggle_overlap", 1, 0);
        if ((RISE && prev_r) || (FALL && prev_f)) chk("toggle_width", 2, 1);
        if (RISE && !prev_r) r++;
        if (FALL && !prev_f) f++;
        prev_r = RISE; prev_f = FALL;
      end
    end
    chk("toggle_rises", r, 5);
    chk("toggle_falls", f, 5);
    chk("toggle_count", COUNT, 5);

    // Glitch rejection: 2-cycle and 4-cycle highs rejected, 5-cycle accepted
    Q_IN = 1'b1; tick(2); Q_IN = 1'b0;
    run(15, r, f);
    chk("glitch2_rises", r, 0);
    chk("glitch2_count", COUNT, 5);
    Q_IN = 1'b1; tick(4); Q_IN = 1'b0;
    run(15, r, f);
    chk("glitch4_rises", r, 0);
    chk("glitch4_count", COUNT, 5);
    Q_IN = 1'b1; tick(5); Q_IN = 1'b0;
    run(20, r, f);
    chk("glitch5_rises", r, 1);
    chk("glitch5_falls", f, 1);
    chk("glitch5_count", COUNT, 6);

    // Counter wrap and sticky overflow
    do_clr();
    for (int i = 0; i < 255; i++) pulse_q();
    chk("wrap_255_count", COUNT, 255);
    chk("wrap_255_ovf", OVF, 0);
    pulse_q();
    chk("wrap_256_count", COUNT, 0);
    chk("wrap_256_ovf", OVF, 1);
    pulse_q();
    chk("wrap_257_count", COUNT, 1);
    chk("wrap_257_ovf", OVF, 1);
    do_clr();
    chk("wrap_clr_count", COUNT, 0);
    chk("wrap_clr_ovf", OVF, 0);

    // CLR coinciding with the RISE edge
    pulse_q();
    chk("clrrise_pre_count", COUNT, 1);
    Q_IN = 1'b1; tick(6);
    CLR = 1'b1; tick(1); CLR = 1'b0;
    chk("clrrise_rise", RISE, 1);
    chk("clrrise_count", COUNT, 0);
    tick(13);
    Q_IN = 1'b0; tick(10);
    pulse_q();
    chk("clrrise_next_count", COUNT, 1);

    // Reset mid-debounce (S_WAIT_HI with deb_cnt=2)
    Q_IN = 1'b1; tick(5);
    RST_N = 1'b0;
    #1;
    chk("midrst_count", COUNT, 0);
    chk("midrst_qstable", Q_STABLE, 0);
    chk("midrst_rise", RISE, 0);
    run(3, r, f);
    chk("midrst_rises", r, 0);
    RST_N = 1'b1;
    run(6, r, f);
    chk("midrel_rises_e6", r, 0);
    chk("midrel_count_e6", COUNT, 0);
    tick(1);
    chk("midrel_rise_e7", RISE, 1);
    chk("midrel_count_e7", COUNT, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_q_edge_counter
